// File: rtl/dpram_param_clr.sv
// ---------------------------------------------------------------------------
// dpram_param_clr
//   Parametrised dual-port distributed RAM for palette / scanline / sprite
//   buffers in the video path. Port A reads and writes, port B is read-only,
//   both run on a single clock. A built-in sequential clear engine writes
//   CLR_VALUE to every word, either after reset (CLR_ON_RST=1) or on request.
//
// Parameters
//   DATA_WIDTH  word width in bits (1..64)
//   ADDR_WIDTH  address bits, depth = 2**ADDR_WIDTH (2..8)
//   OUT_REG     0 = asynchronous read, 1 = registered read (1-cycle latency)
//   WR_FIRST    OUT_REG=1 only: 1 = write-first bypass, 0 = read-first
//   CLR_ON_RST  1 = run the clear sequence after reset
//   CLR_VALUE   value written by the clear engine
//
// Ports
//   clk      in   clock, all state on rising edge
//   rst      in   synchronous reset, active-low
//   clr_req  in   1-cycle pulse: start clear sequence (ignored while busy)
//   busy     out  high while the clear sequence runs
//   addr_a   in   port A address
//   wren_a   in   port A write enable (dropped while busy)
//   din_a    in   port A write data
//   dout_a   out  port A read data
//   rden_b   in   port B read enable (registered mode only)
//   addr_b   in   port B address
//   dout_b   out  port B read data
// ---------------------------------------------------------------------------
module dpram_param_clr #(
  parameter int unsigned            DATA_WIDTH = 30,
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            OUT_REG    = 0,
  parameter int unsigned            WR_FIRST   = 1,
  parameter int unsigned            CLR_ON_RST = 1,
  parameter logic [DATA_WIDTH-1:0]  CLR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  rden_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
  logic                    w_busy;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   w_rd_a;
  logic [DATA_WIDTH-1:0]   w_rd_b;

  // -------------------------------------------------------------------------
  // Clear engine FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_busy = 1'b1;
        // Counter wraps to zero on the last word, so it is ready for the
        // next sequence without a separate reload.
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign busy = w_busy;

  // -------------------------------------------------------------------------
  // Storage: the clear engine owns the single write port while busy, user
  // writes are dropped during that time.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_cnt] <= CLR_VALUE;
    end else if (wren_a) begin
      r_mem[addr_a] <= din_a;
    end
  end

  assign w_rd_a = r_mem[addr_a];
  assign w_rd_b = r_mem[addr_b];

  // -------------------------------------------------------------------------
  // Read paths
  // -------------------------------------------------------------------------
  generate
    if (OUT_REG == 0) begin : g_async
      logic w_unused_rden_b;
      assign w_unused_rden_b = rden_b;

      assign dout_a = w_busy ? CLR_VALUE : w_rd_a;
      assign dout_b = w_busy ? CLR_VALUE : w_rd_b;
    end else begin : g_sync
      logic [DATA_WIDTH-1:0] r_dout_a;
      logic [DATA_WIDTH-1:0] r_dout_b;
      logic                  w_byp_a;
      logic                  w_byp_b;

      // The array read happens before the non-blocking write lands, so the
      // unbypassed path is naturally read-first.
      assign w_byp_a = (WR_FIRST != 0) && wren_a;
      assign w_byp_b = (WR_FIRST != 0) && wren_a && (addr_b == addr_a);

      always_ff @(posedge clk) begin
        if (!rst || w_busy) begin
          r_dout_a <= CLR_VALUE;
          r_dout_b <= CLR_VALUE;
        end else begin
          r_dout_a <= w_byp_a ? din_a : w_rd_a;
          if (rden_b) begin
            r_dout_b <= w_byp_b ? din_a : w_rd_b;
          end
        end
      end

      assign dout_a = r_dout_a;
      assign dout_b = r_dout_b;
    end
  endgenerate

endmodule
